// File: rtl/decode_stage.sv
// RV32I decode stage: registered output plus one skid entry, valid/ready on both sides, flush on redirect.
// Optional macro DECODE_PERF_CNT_EN adds perf_decoded / perf_illegal transfer counters.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_wen,
  output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal
`endif
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_N = 3'd6;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_wen;
    logic            illegal;
  } dec_t;

  function automatic logic signed [XLEN-1:0] f_sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic dec_t f_decode(input logic [31:0] i, input logic [PC_W-1:0] pc);
    dec_t d;
    logic legal, use1, use2, used;
    logic signed [31:0] imm32;
    d = '0;
    d.pc = pc;
    d.opcode = i[6:0];
    d.rd = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.funct3 = i[14:12];
    d.funct7 = i[31:25];
    d.fmt = FMT_N;
    legal = 1'b1;
    use1 = 1'b0;
    use2 = 1'b0;
    used = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin d.fmt = FMT_U; used = 1'b1; end
      7'b1101111: begin d.fmt = FMT_J; used = 1'b1; end
      7'b1100111: begin d.fmt = FMT_I; use1 = 1'b1; used = 1'b1; legal = (i[14:12] == 3'b000); end
      7'b1100011: begin d.fmt = FMT_B; use1 = 1'b1; use2 = 1'b1; legal = (i[14:13] != 2'b01); end
      7'b0000011, 7'b0010011: begin d.fmt = FMT_I; use1 = 1'b1; used = 1'b1; end
      7'b0100011: begin d.fmt = FMT_S; use1 = 1'b1; use2 = 1'b1; end
      7'b0110011: begin d.fmt = FMT_R; use1 = 1'b1; use2 = 1'b1; used = 1'b1; end
      7'b0001111: d.fmt = FMT_N;
      7'b1110011: d.fmt = FMT_I;
      default:    legal = 1'b0;
    endcase
    case (d.fmt)
      FMT_I:   imm32 = {{20{i[31]}}, i[31:20]};
      FMT_S:   imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   imm32 = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   imm32 = {i[31:12], 12'b0};
      FMT_J:   imm32 = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Illegal encodings still flow downstream, but scrubbed of any side effects.
    if (!legal) begin
      d.fmt = FMT_N;
      d.illegal = 1'b1;
    end else begin
      d.imm = f_sext(imm32);
      d.rs1_en = use1;
      d.rs2_en = use2;
      d.rd_wen = used && (i[11:7] != 5'd0);
    end
    return d;
  endfunction

  dec_t w_dec_p0;
  dec_t r_dec_p1;
  dec_t r_skid_p1;
  logic r_vld_p1;
  logic r_skid_vld_p1;
  logic w_acc_p0;
  logic w_out_free;

  assign w_dec_p0   = f_decode(in_instr, in_pc);
  assign in_ready   = !r_skid_vld_p1;
  assign w_acc_p0   = in_valid && in_ready;
  assign w_out_free = !r_vld_p1 || out_ready;

  // ---- stage p0 -> p1: output register and skid entry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_dec_p1      <= '0;
    end else if (flush) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_vld_p1) begin
        r_dec_p1      <= r_skid_p1;
        r_vld_p1      <= 1'b1;
        r_skid_vld_p1 <= 1'b0;
      end else if (w_acc_p0) begin
        r_dec_p1 <= w_dec_p0;
        r_vld_p1 <= 1'b1;
      end else begin
        r_vld_p1 <= 1'b0;
      end
    end else if (w_acc_p0) begin
      r_skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_out_free && w_acc_p0) r_skid_p1 <= w_dec_p0;
  end

  assign out_valid   = r_vld_p1;
  assign out_pc      = r_dec_p1.pc;
  assign out_opcode  = r_dec_p1.opcode;
  assign out_rd      = r_dec_p1.rd;
  assign out_rs1     = r_dec_p1.rs1;
  assign out_rs2     = r_dec_p1.rs2;
  assign out_funct3  = r_dec_p1.funct3;
  assign out_funct7  = r_dec_p1.funct7;
  assign out_imm     = r_dec_p1.imm;
  assign out_fmt     = r_dec_p1.fmt;
  assign out_rs1_en  = r_dec_p1.rs1_en;
  assign out_rs2_en  = r_dec_p1.rs2_en;
  assign out_rd_wen  = r_dec_p1.rd_wen;
  assign out_illegal = r_dec_p1.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic        w_xfer_p1;
  logic [31:0] r_perf_dec;
  logic [31:0] r_perf_ill;
  assign w_xfer_p1 = r_vld_p1 && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_dec <= '0;
      r_perf_ill <= '0;
    end else if (w_xfer_p1) begin
      r_perf_dec <= r_perf_dec + 32'd1;
      if (r_dec_p1.illegal) r_perf_ill <= r_perf_ill + 32'd1;
    end
  end

  assign perf_decoded = r_perf_dec;
  assign perf_illegal = r_perf_ill;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized scoreboard run.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic        out_rs1_en, out_rs2_en, out_rd_wen, out_illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded, perf_illegal;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
    .out_rd_wen(out_rd_wen), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
    , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        rs1_en, rs2_en, rd_wen, ill;
  } dec_t;

  // Reference decoder: immediates built as unsigned fields minus 2^width when the sign bit is set.
  function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    dec_t e;
    logic ok, u1, u2, ud;
    e = '0;
    e.pc = pc; e.opc = i[6:0]; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.f3 = i[14:12]; e.f7 = i[31:25];
    ok = 1'b1; u1 = 1'b0; u2 = 1'b0; ud = 1'b0; e.fmt = 3'd6;
    case (i[6:0])
      7'h37, 7'h17: begin e.fmt = 3'd4; ud = 1'b1; end
      7'h6F: begin e.fmt = 3'd5; ud = 1'b1; end
      7'h67: begin e.fmt = 3'd1; u1 = 1'b1; ud = 1'b1; ok = (e.f3 == 3'd0); end
      7'h63: begin e.fmt = 3'd3; u1 = 1'b1; u2 = 1'b1; ok = (e.f3 != 3'd2) && (e.f3 != 3'd3); end
      7'h03, 7'h13: begin e.fmt = 3'd1; u1 = 1'b1; ud = 1'b1; end
      7'h23: begin e.fmt = 3'd2; u1 = 1'b1; u2 = 1'b1; end
      7'h33: begin e.fmt = 3'd0; u1 = 1'b1; u2 = 1'b1; ud = 1'b1; end
      7'h0F: e.fmt = 3'd6;
      7'h73: e.fmt = 3'd1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.fmt = 3'd6;
      e.ill = 1'b1;
    end else begin
      case (e.fmt)
        3'd1: e.imm = {20'd0, i[31:20]} - (i[31] ? 32'd4096 : 32'd0);
        3'd2: e.imm = {20'd0, i[31:25], i[11:7]} - (i[31] ? 32'd4096 : 32'd0);
        3'd3: e.imm = {19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0} - (i[31] ? 32'd8192 : 32'd0);
        3'd4: e.imm = i[31:12] * 32'd4096;
        3'd5: e.imm = {11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0} - (i[31] ? 32'h0020_0000 : 32'd0);
        default: e.imm = 32'd0;
      endcase
      e.rs1_en = u1; e.rs2_en = u2; e.rd_wen = ud && (e.rd != 5'd0);
    end
    return e;
  endfunction

  function automatic dec_t got();
    return {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
            out_fmt, out_rs1_en, out_rs2_en, out_rd_wen, out_illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    tick(); tick();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ctrl: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    n_chk++;
    if (got() !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", got());
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send1(32'hFFF00093, 32'h100);
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || {out_fmt, out_rd, out_rs1, out_imm, out_rs1_en, out_rs2_en, out_rd_wen, out_illegal}
        !== {3'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 4'b1010}) begin
      n_fail++; $display("FAIL addi: v=%b fmt=%0d rd=%0d rs1=%0d imm=%h en=%b%b%b ill=%b, required v=1 fmt=1 rd=1 rs1=0 imm=ffffffff en=101 ill=0",
                         out_valid, out_fmt, out_rd, out_rs1, out_imm, out_rs1_en, out_rs2_en, out_rd_wen, out_illegal);
    end
    n_chk++;
    if (got() !== ref_decode(32'hFFF00093, 32'h100)) begin
      n_fail++; $display("FAIL addi_full: got %h, required %h", got(), ref_decode(32'hFFF00093, 32'h100));
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send1(32'h0020A423, 32'h200); tick();
    send1(32'hFE000EE3, 32'h204);
    n_chk++;
    if (out_valid !== 1'b1 || out_fmt !== 3'd2 || out_imm !== 32'd8 || out_rd_wen !== 1'b0 || out_pc !== 32'h200) begin
      n_fail++; $display("FAIL sw: v=%b fmt=%0d imm=%h rd_wen=%b pc=%h, required 1/2/8/0/200", out_valid, out_fmt, out_imm, out_rd_wen, out_pc);
    end
    tick();
    send1(32'h123452B7, 32'h208);
    n_chk++;
    if (out_valid !== 1'b1 || out_fmt !== 3'd3 || out_imm !== 32'hFFFFFFFC || out_pc !== 32'h204) begin
      n_fail++; $display("FAIL beq: v=%b fmt=%0d imm=%h pc=%h, required 1/3/fffffffc/204", out_valid, out_fmt, out_imm, out_pc);
    end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out_fmt !== 3'd4 || out_rd !== 5'd5 || out_imm !== 32'h12345000 || out_pc !== 32'h208) begin
      n_fail++; $display("FAIL lui: v=%b fmt=%0d rd=%0d imm=%h pc=%h, required 1/4/5/12345000/208", out_valid, out_fmt, out_rd, out_imm, out_pc);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3];
    logic [31:0] pcq [$];
    int acc;
    ins[0] = 32'h00100093; ins[1] = 32'h00200113; ins[2] = 32'h00300193;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      send1(ins[acc], 32'h300 + 32'(acc) * 4);
      if (in_ready) acc++;
      tick();
    end
    n_chk++;
    if (acc !== 2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2/0", acc, in_ready);
    end
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_imm !== 32'd1) begin
      n_fail++; $display("FAIL bp_hold: v=%b pc=%h imm=%h, required 1/300/1", out_valid, out_pc, out_imm);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic take;
      in_valid = (acc < 3);
      if (acc < 3) begin in_instr = ins[acc]; in_pc = 32'h300 + 32'(acc) * 4; end
      if (out_valid && out_ready) pcq.push_back(out_pc);
      take = in_valid && in_ready;
      tick();
      if (take) acc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (pcq.size() != 3 || pcq[0] !== 32'h300 || pcq[1] !== 32'h304 || pcq[2] !== 32'h308) begin
      n_fail++; $display("FAIL bp_order: got %0d outputs %p, required 300 304 308", pcq.size(), pcq);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'h00000000; bad[1] = 32'h00001067;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send1(bad[k], 32'h400 + 32'(k));
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd6 || out_imm !== 32'd0 ||
          {out_rs1_en, out_rs2_en, out_rd_wen} !== 3'b000) begin
        n_fail++; $display("FAIL illegal_%0d: v=%b ill=%b fmt=%0d imm=%h en=%b%b%b, required 1/1/6/0/000",
                           k, out_valid, out_illegal, out_fmt, out_imm, out_rs1_en, out_rs2_en, out_rd_wen);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    send1(32'h00500293, 32'h500); tick();
    send1(32'h00600313, 32'h504); tick();
    send1(32'h00700393, 32'h508);
    flush = 1'b1;
    n_chk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    n_chk++;
    if (seen != 0) begin n_fail++; $display("FAIL flush_leak: %0d outputs appeared, required 0", seen); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send1(32'h00800413, 32'h600); tick();
    send1(32'h00900493, 32'h604); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got() !== '0) begin
      n_fail++; $display("FAIL async_reset: v=%b in_ready=%b data=%h, required 0/1/0", out_valid, in_ready, got());
    end
`ifdef DECODE_PERF_CNT_EN
    n_chk++;
    if (perf_decoded !== 32'd0 || perf_illegal !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_perf: %0d/%0d, required 0/0", perf_decoded, perf_illegal);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    dec_t exp_q [$];
    logic [6:0] opc_tab [12];
    int pd, pi;
    logic acc, xfer;
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
    pd = 0; pi = 0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ins;
      int sel;
      ins = $urandom;
      sel = $urandom_range(0, 12);
      if (sel < 12) ins[6:0] = opc_tab[sel];
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      in_valid = ($urandom_range(0, 9) < 7);
      in_instr = ins; in_pc = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      n_chk++;
      if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_hs c=%0d: in_ready=%b out_valid=%b, required occupancy %0d", c, in_ready, out_valid, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        n_chk++;
        if (got() !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_data c=%0d: got %h, required %h", c, got(), exp_q[0]);
        end
      end
      acc = in_valid && (exp_q.size() < 2);
      xfer = (exp_q.size() > 0) && out_ready;
      if (xfer) begin pd++; if (exp_q[0].ill) pi++; end
      if (flush) exp_q.delete();
      else begin
        if (xfer) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_decode(in_instr, in_pc));
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
`ifdef DECODE_PERF_CNT_EN
    n_chk++;
    if (perf_decoded !== 32'(pd) || perf_illegal !== 32'(pi)) begin
      n_fail++; $display("FAIL rnd_perf: %0d/%0d, required %0d/%0d", perf_decoded, perf_illegal, pd, pi);
    end
`endif
  endtask

`ifdef DECODE_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] seq [7];
    seq = '{32'h00100093, 32'h00000000, 32'h0020A423, 32'h123452B7, 32'h00001067, 32'hFE000EE3, 32'h00208033};
    rst_n = 1'b0; #1 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin send1(seq[k], 32'h700 + 32'(k)); tick(); end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (perf_decoded !== 32'd7 || perf_illegal !== 32'd2) begin
      n_fail++; $display("FAIL perf: %0d/%0d, required 7/2", perf_decoded, perf_illegal);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
`ifdef DECODE_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
